// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, oversampling constants and
// the even-parity helper used by both the receiver and the transmitter.
package uart_pkg;

  // Number of baud ticks per bit, and the tick indices used for sampling.
  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 7;
  localparam int LAST_TICK  = 15;

  // One-hot state encoding. Bit 0 is IDLE, so "busy" is the inverse of that bit.
  typedef enum logic [4:0] {
    ST_IDLE   = 5'b00001,
    ST_START  = 5'b00010,
    ST_DATA   = 5'b00100,
    ST_PARITY = 5'b01000,
    ST_STOP   = 5'b10000
  } uart_state_e;

  // Even parity holds when the XOR of all data bits and the parity bit is 0.
  // Callers zero-extend the data word to 32 bits. Zero bits do not change the XOR.
  function automatic logic even_parity_ok(input logic [31:0] data, input logic par);
    return ((^data) ^ par) == 1'b0;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Metastability synchroniser for the asynchronous RX pin.
// The chain presets to 1 so that reset looks like an idle line.
module uart_rx_sync #(
  parameter int NB_SYNC = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_rx_data,
  output logic rx_s
);

  logic [NB_SYNC-1:0] sync_r;

  // Shift the raw line through NB_SYNC flops. The chain resets to the idle level.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sync_r <= {NB_SYNC{1'b1}};
    end else begin
      sync_r <= {sync_r[NB_SYNC-2:0], i_rx_data};
    end
  end

  assign rx_s = sync_r[NB_SYNC-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, LSB first, one stop bit.
// The optional even parity bit is enabled by defining UART_RX_PARITY_EN.
// Each good byte is presented with a one-clock o_valid strobe.
// A low stop bit gives a one-clock o_frame_err strobe. After a frame error,
// the receiver does not re-arm until the line has been seen high again.
module uart_rx
  import uart_pkg::*;
#(
  parameter int NB_DATA = 8,
  parameter int NB_SYNC = 2
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_tick,
  input  logic               i_rx_data,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_valid,
  output logic               o_frame_err,
  output logic               o_parity_err,
  output logic               o_busy
);

  localparam int NB_BIT_CNT = $clog2(NB_DATA + 1);

  logic                  rx_s;
  logic                  par_ok_s;
  uart_state_e           state_r;
  logic [3:0]            tick_cnt_r;
  logic [NB_BIT_CNT-1:0] bit_cnt_r;
  logic [NB_DATA-1:0]    shreg_r;
  logic [NB_DATA-1:0]    data_r;
  logic                  valid_r;
  logic                  frame_err_r;
  logic                  armed_r;

  uart_rx_sync #(
    .NB_SYNC   (NB_SYNC)
  ) u_sync (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_rx_data (i_rx_data),
    .rx_s      (rx_s)
  );

`ifdef UART_RX_PARITY_EN
  logic parity_bit_r;
  logic parity_err_r;

  // Check the received word against the captured parity bit.
  always_comb begin
    par_ok_s = 1'b0;
    par_ok_s = even_parity_ok(32'(shreg_r), parity_bit_r);
  end
`else
  assign par_ok_s = 1'b1;
`endif

  // Receiver FSM: detect the start bit, sample at mid-bit, and strobe the result.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_r      <= ST_IDLE;
      tick_cnt_r   <= 4'd0;
      bit_cnt_r    <= '0;
      shreg_r      <= '0;
      data_r       <= '0;
      valid_r      <= 1'b0;
      frame_err_r  <= 1'b0;
      armed_r      <= 1'b1;
`ifdef UART_RX_PARITY_EN
      parity_bit_r <= 1'b0;
      parity_err_r <= 1'b0;
`endif
    end else begin
      valid_r     <= 1'b0;
      frame_err_r <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_r <= 1'b0;
`endif
      case (state_r)
        ST_IDLE: begin
          if (rx_s) begin
            armed_r <= 1'b1;
          end else if (armed_r) begin
            tick_cnt_r <= 4'd0;
            state_r    <= ST_START;
          end else begin
            armed_r <= 1'b0;
          end
        end

        ST_START: begin
          if (i_tick) begin
            if (tick_cnt_r == 4'(MID_SAMPLE)) begin
              tick_cnt_r <= 4'd0;
              bit_cnt_r  <= '0;
              if (!rx_s) begin
                state_r <= ST_DATA;
              end else begin
                state_r <= ST_IDLE;
              end
            end else begin
              tick_cnt_r <= tick_cnt_r + 4'd1;
            end
          end
        end

        ST_DATA: begin
          if (i_tick) begin
            if (tick_cnt_r == 4'(LAST_TICK)) begin
              tick_cnt_r <= 4'd0;
              shreg_r    <= {rx_s, shreg_r[NB_DATA-1:1]};
              bit_cnt_r  <= bit_cnt_r + NB_BIT_CNT'(1);
              if (bit_cnt_r == NB_BIT_CNT'(NB_DATA - 1)) begin
`ifdef UART_RX_PARITY_EN
                state_r <= ST_PARITY;
`else
                state_r <= ST_STOP;
`endif
              end
            end else begin
              tick_cnt_r <= tick_cnt_r + 4'd1;
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (i_tick) begin
            if (tick_cnt_r == 4'(LAST_TICK)) begin
              tick_cnt_r   <= 4'd0;
              parity_bit_r <= rx_s;
              state_r      <= ST_STOP;
            end else begin
              tick_cnt_r <= tick_cnt_r + 4'd1;
            end
          end
        end
`endif

        ST_STOP: begin
          if (i_tick) begin
            if (tick_cnt_r == 4'(LAST_TICK)) begin
              tick_cnt_r <= 4'd0;
              state_r    <= ST_IDLE;
              if (rx_s) begin
                if (par_ok_s) begin
                  data_r  <= shreg_r;
                  valid_r <= 1'b1;
                end
              end else begin
                // A low stop bit may be a line break. Wait for high before re-arming.
                frame_err_r <= 1'b1;
                armed_r     <= 1'b0;
              end
`ifdef UART_RX_PARITY_EN
              parity_err_r <= ~par_ok_s;
`endif
            end else begin
              tick_cnt_r <= tick_cnt_r + 4'd1;
            end
          end
        end

        default: begin
          state_r    <= ST_IDLE;
          tick_cnt_r <= 4'd0;
          bit_cnt_r  <= '0;
        end
      endcase
    end
  end

  assign o_data      = data_r;
  assign o_valid     = valid_r;
  assign o_frame_err = frame_err_r;
  assign o_busy      = ~state_r[0];
`ifdef UART_RX_PARITY_EN
  assign o_parity_err = parity_err_r;
`else
  assign o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx: good frames, back-to-back frames, false
// start, frame error with line break, reset mid-frame, and optional parity.
module tb_uart_rx;

  localparam int BIT_CLKS = 64;  // 16 ticks per bit, one tick every 4 clocks

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic       i_tick;
  logic       i_rx_data;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_frame_err;
  logic       o_parity_err;
  logic       o_busy;

  int         n_checks = 0;
  int         n_fail = 0;
  int         valid_cnt = 0;
  int         ferr_cnt = 0;
  int         perr_cnt = 0;
  int         tick_ph = 0;
  logic [7:0] data_hist[$];
  logic       busy_at_valid = 1'b1;
  logic       busy_mid = 1'b0;

  uart_rx #(.NB_DATA(8), .NB_SYNC(2)) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_tick       (i_tick),
    .i_rx_data    (i_rx_data),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .o_frame_err  (o_frame_err),
    .o_parity_err (o_parity_err),
    .o_busy       (o_busy)
  );

  always #5 i_clk = ~i_clk;

  // Baud tick: one clock wide, every fourth clock.
  initial begin
    i_tick = 1'b0;
    forever begin
      @(negedge i_clk);
      tick_ph = (tick_ph + 1) % 4;
      i_tick = (tick_ph == 0);
    end
  end

  // Strobe monitor: count pulses and log the received bytes.
  always @(negedge i_clk) begin
    if (o_valid === 1'b1) begin
      valid_cnt++;
      data_hist.push_back(o_data);
      busy_at_valid = o_busy;
    end
    if (o_frame_err === 1'b1) ferr_cnt++;
    if (o_parity_err === 1'b1) perr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int nbits);
    i_rx_data = 1'b1;
    repeat (nbits * BIT_CLKS) @(negedge i_clk);
  endtask

  // Send one frame. A non-negative abort_bit pulses reset in the middle of
  // that data bit. The task then returns the line to idle.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                            input int abort_bit);
    i_rx_data = 1'b0;
    repeat (BIT_CLKS) @(negedge i_clk);
    for (int i = 0; i < 8; i++) begin
      i_rx_data = d[i];
      if (i == abort_bit) begin
        repeat (BIT_CLKS / 2) @(negedge i_clk);
        i_reset = 1'b1;
        @(negedge i_clk);
        i_reset = 1'b0;
        i_rx_data = 1'b1;
        return;
      end else if (i == 0) begin
        repeat (BIT_CLKS / 2) @(negedge i_clk);
        busy_mid = o_busy;
        repeat (BIT_CLKS / 2) @(negedge i_clk);
      end else begin
        repeat (BIT_CLKS) @(negedge i_clk);
      end
    end
`ifdef UART_RX_PARITY_EN
    i_rx_data = par;
    repeat (BIT_CLKS) @(negedge i_clk);
`else
    if (par !== 1'b0 && par !== 1'b1) $display("note: parity argument undefined");
`endif
    i_rx_data = stop;
    repeat (BIT_CLKS) @(negedge i_clk);
  endtask

  initial begin
    int v0, f0;
    i_reset   = 1'b1;
    i_rx_data = 1'b1;
    repeat (5) @(negedge i_clk);
    check("rst_data", 32'(o_data), 32'h0);
    check("rst_valid", 32'(o_valid), 32'h0);
    check("rst_ferr", 32'(o_frame_err), 32'h0);
    check("rst_perr", 32'(o_parity_err), 32'h0);
    check("rst_busy", 32'(o_busy), 32'h0);
    i_reset = 1'b0;
    idle(1);

    // Good frame 0xA5
    v0 = valid_cnt; f0 = ferr_cnt;
    send_frame(8'hA5, 1'b0, 1'b1, -1);
    idle(1);
    check("a5_valid_cnt", 32'(valid_cnt - v0), 32'd1);
    check("a5_data", 32'(o_data), 32'hA5);
    check("a5_ferr", 32'(ferr_cnt - f0), 32'd0);
    check("a5_busy_mid", 32'(busy_mid), 32'd1);
    check("a5_busy_at_valid", 32'(busy_at_valid), 32'd0);
    check("a5_busy_idle", 32'(o_busy), 32'd0);

    // Frame error: 0x3C with a low stop bit, then a 2-bit break
    v0 = valid_cnt; f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0, 1'b0, -1);
    i_rx_data = 1'b0;
    repeat (2 * BIT_CLKS) @(negedge i_clk);
    idle(1);
    check("ferr_cnt", 32'(ferr_cnt - f0), 32'd1);
    check("ferr_no_valid", 32'(valid_cnt - v0), 32'd0);
    check("ferr_data_kept", 32'(o_data), 32'hA5);
    send_frame(8'h81, 1'b0, 1'b1, -1);
    idle(1);
    check("81_valid_cnt", 32'(valid_cnt - v0), 32'd1);
    check("81_data", 32'(o_data), 32'h81);
    check("81_ferr_total", 32'(ferr_cnt - f0), 32'd1);

    // Back-to-back frames 0x00 then 0xFF
    v0 = valid_cnt; f0 = ferr_cnt;
    send_frame(8'h00, 1'b0, 1'b1, -1);
    send_frame(8'hFF, 1'b0, 1'b1, -1);
    idle(1);
    check("b2b_valid_cnt", 32'(valid_cnt - v0), 32'd2);
    check("b2b_first", 32'(data_hist[data_hist.size() - 2]), 32'h00);
    check("b2b_second", 32'(data_hist[data_hist.size() - 1]), 32'hFF);
    check("b2b_ferr", 32'(ferr_cnt - f0), 32'd0);

    // False start: 5 ticks low, then high
    v0 = valid_cnt; f0 = ferr_cnt;
    i_rx_data = 1'b0;
    repeat (12) @(negedge i_clk);
    check("fs_busy_during", 32'(o_busy), 32'd1);
    repeat (8) @(negedge i_clk);
    idle(2);
    check("fs_no_valid", 32'(valid_cnt - v0), 32'd0);
    check("fs_no_ferr", 32'(ferr_cnt - f0), 32'd0);
    check("fs_busy_after", 32'(o_busy), 32'd0);
    send_frame(8'h3C, 1'b0, 1'b1, -1);
    idle(1);
    check("3c_valid_cnt", 32'(valid_cnt - v0), 32'd1);
    check("3c_data", 32'(o_data), 32'h3C);

    // Reset during data bit 4 of 0x5A
    v0 = valid_cnt; f0 = ferr_cnt;
    send_frame(8'h5A, 1'b0, 1'b1, 4);
    check("rstmid_data", 32'(o_data), 32'h0);
    check("rstmid_busy", 32'(o_busy), 32'd0);
    check("rstmid_valid", 32'(o_valid), 32'd0);
    idle(2);
    check("rstmid_no_strobe", 32'(valid_cnt - v0 + ferr_cnt - f0), 32'd0);
    send_frame(8'h5A, 1'b0, 1'b1, -1);
    idle(1);
    check("5a_valid_cnt", 32'(valid_cnt - v0), 32'd1);
    check("5a_data", 32'(o_data), 32'h5A);

`ifdef UART_RX_PARITY_EN
    // Parity: 0x07 has three ones, so even parity needs a parity bit of 1
    v0 = valid_cnt;
    send_frame(8'h07, 1'b1, 1'b1, -1);
    idle(1);
    check("par_good_valid", 32'(valid_cnt - v0), 32'd1);
    check("par_good_data", 32'(o_data), 32'h07);
    check("par_good_perr", 32'(perr_cnt), 32'd0);
    v0 = valid_cnt;
    send_frame(8'h07, 1'b0, 1'b1, -1);
    idle(1);
    check("par_bad_perr", 32'(perr_cnt), 32'd1);
    check("par_bad_no_valid", 32'(valid_cnt - v0), 32'd0);
`else
    check("no_parity_err", 32'(perr_cnt), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
